// File: rtl/ir_ctrl_pkg.sv
// Shared definitions for the interrupt source controller: register map,
// controller state encoding and CAUSE register layout.
package ir_ctrl_pkg;

    // Software-visible register addresses
    localparam logic [1:0] IR_A_PEND  = 2'd0;
    localparam logic [1:0] IR_A_MASK  = 2'd1;
    localparam logic [1:0] IR_A_CAUSE = 2'd2;
    localparam logic [1:0] IR_A_CTRL  = 2'd3;

    // CAUSE register layout: in-service flag on top, dispatched index at the bottom
    localparam int CAUSE_INSVC_BIT = 31;
    localparam int CAUSE_IDX_W     = 5;

    // CTRL register layout: only the global enable is implemented
    localparam int CTRL_EN_BIT = 0;

    // Controller states: waiting, one-cycle request to CP0, handler running
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } irState_t;

    // Assemble the CAUSE read word from the in-service flag and source index
    function automatic logic [31:0] causeWord(input logic inSvc,
                                              input logic [CAUSE_IDX_W-1:0] idx);
        logic [31:0] w;
        w = '0;
        w[CAUSE_INSVC_BIT]     = inSvc;
        w[CAUSE_IDX_W-1:0]     = idx;
        return w;
    endfunction

endpackage

// File: rtl/ir_ctrl_sync_edge.sv
// Per-source synchroniser and rising-edge detector. The raw device line is
// passed through a chain of SYNC_STAGES flops; a rise is reported for exactly
// one cycle when the synchronised level goes from 0 to 1.
module ir_ctrl_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_src,
    output logic o_rise
);

    // r_sync[0] takes the raw line; the MSB is the fully synchronised level
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw line through the synchroniser and remember the last synced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // A held-high line only produces one rise; a new rise needs a synced low first
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/ir_ctrl.sv
// Interrupt source controller in front of the CP0 external interrupt input.
// Latches rising edges of the device lines as pending, masks and prioritises
// them (lowest index wins), pulses ir_out for one cycle per dispatch and then
// holds off further dispatches until CP0 reports ERET. Software sees PEND
// (write-1-to-clear), MASK, CAUSE (read-only) and CTRL (global enable).
module ir_ctrl
    import ir_ctrl_pkg::*;
#(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    output logic             ir_out,
    input  logic             eret,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      data_w,
    output logic [31:0]      data_r
);

    // Edge detection outputs, one per source
    logic [N_SRC-1:0]       w_rise;

    // Software-visible state
    logic [N_SRC-1:0]       r_pend;
    logic [N_SRC-1:0]       r_mask;
    logic                   r_en;
    logic [CAUSE_IDX_W-1:0] r_causeIdx;
    logic                   r_inService;

    // Controller state and its registered request output
    irState_t               r_state;
    logic                   r_irOut;

    // Arbitration results
    logic [N_SRC-1:0]       w_cand;
    logic                   w_anyCand;
    logic [CAUSE_IDX_W-1:0] w_winIdx;
    logic [N_SRC-1:0]       w_winOneHot;
    logic                   w_dispatch;

    // Register write decode and pending-clear vector
    logic                   w_wrPend;
    logic                   w_wrMask;
    logic                   w_wrCtrl;
    logic [N_SRC-1:0]       w_pendClr;
    logic [31:0]            w_readData;

    // Upper write-data bits beyond N_SRC have no storage behind them
    logic                   w_unused;
    assign w_unused = ^data_w;

    // One synchroniser plus edge detector per device line
    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        ir_ctrl_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_syncEdge (
            .clk    (clk),
            .rst    (rst),
            .i_src  (src[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_wrPend = we & (addr == IR_A_PEND);
    assign w_wrMask = we & (addr == IR_A_MASK);
    assign w_wrCtrl = we & (addr == IR_A_CTRL);

    // Only pending sources that are unmasked compete for dispatch
    assign w_cand    = r_pend & r_mask;
    assign w_anyCand = |w_cand;

    // Priority encoder: scan downwards so the lowest set index is the last to win
    always_comb begin
        w_winIdx    = '0;
        w_winOneHot = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_winIdx       = CAUSE_IDX_W'(i);
                w_winOneHot    = '0;
                w_winOneHot[i] = 1'b1;
            end
        end
    end

    // A new request is only launched from IDLE with the global enable set
    assign w_dispatch = (r_state == S_IDLE) & r_en & w_anyCand;

    // Software W1C and the dispatched bit both clear; a rise in the same cycle still sets
    assign w_pendClr = (w_wrPend   ? data_w[N_SRC-1:0] : '0) |
                       (w_dispatch ? w_winOneHot       : '0);

    // Pending register: keep uncleared bits, then OR in fresh rising edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_pendClr) | w_rise;
        end
    end

    // Mask and global enable are plain software-written registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
            r_en   <= 1'b0;
        end else begin
            if (w_wrMask) begin
                r_mask <= data_w[N_SRC-1:0];
            end
            if (w_wrCtrl) begin
                r_en <= data_w[CTRL_EN_BIT];
            end
        end
    end

    // Dispatch controller: IDLE -> REQ (one-cycle pulse) -> SERVICE until ERET
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_irOut     <= 1'b0;
            r_inService <= 1'b0;
            r_causeIdx  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_irOut <= 1'b0;
                    if (w_dispatch) begin
                        r_state    <= S_REQ;
                        r_irOut    <= 1'b1;
                        r_causeIdx <= w_winIdx;
                    end
                end
                S_REQ: begin
                    r_state     <= S_SERVICE;
                    r_irOut     <= 1'b0;
                    r_inService <= 1'b1;
                end
                S_SERVICE: begin
                    r_irOut <= 1'b0;
                    if (eret) begin
                        r_state     <= S_IDLE;
                        r_inService <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_irOut     <= 1'b0;
                    r_inService <= 1'b0;
                end
            endcase
        end
    end

    assign ir_out = r_irOut;

    // Read mux: unimplemented bits of every register read as zero
    always_comb begin
        w_readData = '0;
        case (addr)
            IR_A_PEND:  w_readData = 32'(r_pend);
            IR_A_MASK:  w_readData = 32'(r_mask);
            IR_A_CAUSE: w_readData = causeWord(r_inService, r_causeIdx);
            IR_A_CTRL:  w_readData[CTRL_EN_BIT] = r_en;
            default:    w_readData = '0;
        endcase
    end

    assign data_r = w_readData;

endmodule

// File: tb/tb_ir_ctrl.sv
// Testbench for ir_ctrl: directed scenarios with literal expectations followed
// by a long randomised run, all checked every cycle against a behavioural model.
module tb_ir_ctrl;

    localparam int N_SRC = 8;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [7:0]  src    = '0;
    logic        ir_out;
    logic        eret   = 1'b0;
    logic        we     = 1'b0;
    logic [1:0]  addr   = 2'd0;
    logic [31:0] data_w = '0;
    logic [31:0] data_r;

    int nCompared   = 0;
    int nMismatched = 0;
    bit mdlOn       = 1'b0;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    ir_ctrl #(
        .N_SRC       (N_SRC),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .src    (src),
        .ir_out (ir_out),
        .eret   (eret),
        .we     (we),
        .addr   (addr),
        .data_w (data_w),
        .data_r (data_r)
    );

    // Behavioural model state: register contents plus "request this cycle" and
    // "handler running" flags; h1..h3 are the last three sampled src values.
    logic [7:0] mPend = '0, mMask = '0;
    logic [7:0] h1 = '0, h2 = '0, h3 = '0;
    logic       mEn = 1'b0, mInSvc = 1'b0, mIrOut = 1'b0;
    logic [4:0] mIdx = '0;

    // Model step: a level seen at edge k becomes pending at edge k+2, so the rise
    // applied now is (sample two edges ago) & ~(sample three edges ago).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPend = '0; mMask = '0; mEn = 1'b0; mInSvc = 1'b0; mIrOut = 1'b0;
            mIdx = '0; h1 = '0; h2 = '0; h3 = '0;
        end else begin : step
            logic [7:0] rise, cand, clr;
            logic       dispatch;
            int         winner;
            rise = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = src;
            cand = mPend & mMask;
            winner = -1;
            for (int i = 0; i < N_SRC; i++)
                if (cand[i] && winner < 0) winner = i;
            dispatch = !mIrOut && !mInSvc && mEn && (winner >= 0);
            clr = '0;
            if (we && addr == 2'd0) clr = data_w[7:0];
            if (dispatch) clr[winner] = 1'b1;
            mPend = (mPend & ~clr) | rise;
            if (we && addr == 2'd1) mMask = data_w[7:0];
            if (we && addr == 2'd3) mEn = data_w[0];
            if (mIrOut) begin
                mIrOut = 1'b0;
                mInSvc = 1'b1;
            end else if (mInSvc) begin
                if (eret) mInSvc = 1'b0;
            end else if (dispatch) begin
                mIrOut = 1'b1;
                mIdx   = winner[4:0];
            end
        end
    end

    // What software should read at a given address according to the model
    function automatic logic [31:0] mRead(input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, mPend};
            2'd1:    return {24'd0, mMask};
            2'd2:    return {mInSvc, 26'd0, mIdx};
            default: return {31'd0, mEn};
        endcase
    endfunction

    // Single comparison point: counts every check and reports any difference
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous check of the request line and the addressed register
    always @(negedge clk) begin
        if (mdlOn && !rst) begin
            checkOutput("ir_out vs model", 32'(ir_out), 32'(mIrOut));
            checkOutput("data_r vs model", data_r, mRead(addr));
        end
    end

    // Drive one cycle of bus/eret inputs; called just after a rising edge
    task automatic applyStimulus(input logic w, input logic [1:0] a,
                                 input logic [31:0] d, input logic e);
        we = w; addr = a; data_w = d; eret = e;
        @(posedge clk); #1;
        we = 1'b0; eret = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Literal register read check; combinational, so only a short settle delay
    task automatic readCheck(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        checkOutput(name, data_r, exp);
    endtask

    // Wait (bounded) for the request pulse; cyc = edges waited
    task automatic waitIrOut(input int maxC, output int cyc);
        cyc = 0;
        while (ir_out !== 1'b1 && cyc < maxC) begin
            idle(1);
            cyc++;
        end
    endtask

    // Count request pulses over n cycles
    task automatic countPulses(input int n, output int p);
        p = 0;
        for (int i = 0; i < n; i++) begin
            idle(1);
            if (ir_out === 1'b1) p++;
        end
    endtask

    initial begin
        int cyc, pulses, b;

        // Reset state
        idle(2);
        checkOutput("reset ir_out", 32'(ir_out), 32'd0);
        readCheck("reset PEND", 2'd0, 32'h0);
        readCheck("reset MASK", 2'd1, 32'h0);
        readCheck("reset CAUSE", 2'd2, 32'h0);
        readCheck("reset CTRL", 2'd3, 32'h0);
        rst = 1'b0;
        mdlOn = 1'b1;
        idle(1);

        // Single source: latency of four edges from first sample to ir_out
        applyStimulus(1'b1, 2'd3, 32'h1, 1'b0);
        applyStimulus(1'b1, 2'd1, 32'h01, 1'b0);
        readCheck("ctrl en readback", 2'd3, 32'h1);
        src[0] = 1'b1;
        waitIrOut(10, cyc);
        checkOutput("single latency", 32'(cyc), 32'd4);
        idle(1);
        readCheck("single CAUSE", 2'd2, 32'h8000_0000);
        readCheck("single PEND", 2'd0, 32'h0);
        src[0] = 1'b0;
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        idle(3);

        // Priority: 5 and 2 together, lowest wins, then 5 after ERET with one idle gap
        applyStimulus(1'b1, 2'd1, 32'hFF, 1'b0);
        src[5] = 1'b1; src[2] = 1'b1;
        waitIrOut(10, cyc);
        checkOutput("prio first req", 32'(ir_out), 32'd1);
        idle(1);
        readCheck("prio CAUSE idx2", 2'd2, 32'h8000_0002);
        readCheck("prio PEND", 2'd0, 32'h20);
        src = '0;
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        checkOutput("prio gap idle", 32'(ir_out), 32'd0);
        idle(1);
        checkOutput("prio second req", 32'(ir_out), 32'd1);
        idle(1);
        readCheck("prio CAUSE idx5", 2'd2, 32'h8000_0005);
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        idle(3);

        // Masking: pending stays pending, unmask dispatches, W1C before unmask cancels
        applyStimulus(1'b1, 2'd1, 32'h00, 1'b0);
        src[3] = 1'b1;
        countPulses(8, pulses);
        checkOutput("masked no req", 32'(pulses), 32'd0);
        readCheck("masked PEND", 2'd0, 32'h08);
        applyStimulus(1'b1, 2'd1, 32'h08, 1'b0);
        waitIrOut(6, cyc);
        checkOutput("unmask req", 32'(ir_out), 32'd1);
        idle(1);
        readCheck("unmask CAUSE", 2'd2, 32'h8000_0003);
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        applyStimulus(1'b1, 2'd1, 32'h00, 1'b0);
        src[3] = 1'b0;
        idle(4);
        src[3] = 1'b1;
        idle(5);
        readCheck("re-pend PEND", 2'd0, 32'h08);
        applyStimulus(1'b1, 2'd0, 32'h08, 1'b0);
        readCheck("w1c PEND", 2'd0, 32'h0);
        applyStimulus(1'b1, 2'd1, 32'h08, 1'b0);
        countPulses(6, pulses);
        checkOutput("cleared no req", 32'(pulses), 32'd0);
        src[3] = 1'b0;
        idle(3);

        // No reentry: ERET during REQ ignored, new edge waits for ERET plus one idle
        applyStimulus(1'b1, 2'd1, 32'h03, 1'b0);
        src[0] = 1'b1;
        waitIrOut(10, cyc);
        checkOutput("reentry first req", 32'(ir_out), 32'd1);
        applyStimulus(1'b0, 2'd2, 32'h0, 1'b1);
        readCheck("eret in REQ ignored", 2'd2, 32'h8000_0000);
        src[1] = 1'b1;
        countPulses(6, pulses);
        checkOutput("no reentry", 32'(pulses), 32'd0);
        readCheck("reentry PEND", 2'd0, 32'h02);
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        checkOutput("reentry gap idle", 32'(ir_out), 32'd0);
        idle(1);
        checkOutput("reentry second req", 32'(ir_out), 32'd1);
        idle(1);
        readCheck("reentry CAUSE", 2'd2, 32'h8000_0001);
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        src = '0;
        idle(3);

        // Set beats clear: W1C of bit4 on the very edge a new rise on bit4 lands
        applyStimulus(1'b1, 2'd1, 32'h00, 1'b0);
        src[4] = 1'b1;
        idle(4);
        readCheck("bit4 pending", 2'd0, 32'h10);
        src[4] = 1'b0;
        idle(3);
        src[4] = 1'b1;
        idle(2);
        applyStimulus(1'b1, 2'd0, 32'h10, 1'b0);
        readCheck("set wins PEND", 2'd0, 32'h10);
        applyStimulus(1'b1, 2'd0, 32'h10, 1'b0);
        readCheck("later clear PEND", 2'd0, 32'h0);

        // Reset in the middle of SERVICE: everything drops without a clock edge
        applyStimulus(1'b1, 2'd1, 32'h10, 1'b0);
        src[4] = 1'b0;
        idle(3);
        src[4] = 1'b1;
        waitIrOut(10, cyc);
        checkOutput("pre-reset req", 32'(ir_out), 32'd1);
        idle(1);
        readCheck("pre-reset CAUSE", 2'd2, 32'h8000_0004);
        #1 rst = 1'b1;
        #1;
        checkOutput("async reset ir_out", 32'(ir_out), 32'd0);
        readCheck("async reset CAUSE", 2'd2, 32'h0);
        readCheck("async reset PEND", 2'd0, 32'h0);
        readCheck("async reset MASK", 2'd1, 32'h0);
        readCheck("async reset CTRL", 2'd3, 32'h0);
        src = '0;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Randomised traffic, checked only by the per-cycle model comparison
        applyStimulus(1'b1, 2'd3, 32'h1, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = int'($urandom_range(0, 7));
                src[b] = ~src[b];
            end
            applyStimulus($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
                          $urandom, $urandom_range(0, 4) == 0);
        end

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
